// File: rtl/cache_assoc_lfu.sv
// N-way set-associative write-back/write-allocate cache core with LFU replacement.
// Optional LFU_AGING_EN: halve a set's counters when a hit would saturate one of them.
module cache_assoc_lfu #(
    parameter int ADDR_W   = 48,
    parameter int WORD_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 10,
    parameter int WAYS     = 4,
    parameter int CNT_W    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           RW,
    input  logic [ADDR_W-1:0]              address,
    input  logic [WORD_W-1:0]              Data_In,
    output logic [WORD_W-1:0]              Data_Out,
    output logic                           ready,
    output logic                           hit,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-OFFSET_W-1:0]     mem_addr,
    output logic [(WORD_W<<OFFSET_W)-1:0]  Line_Out,
    input  logic [(WORD_W<<OFFSET_W)-1:0]  Line_In,
    input  logic                           mem_ack
);
    localparam int LINE_W = WORD_W << OFFSET_W;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t                     state_reg;
    logic [ADDR_W-1:0]          addr_reg;
    logic                       rw_reg;
    logic [WORD_W-1:0]          din_reg;
    logic [WAY_W-1:0]           way_reg;
    logic [LINE_W-1:0]          line_reg;
    logic [WORD_W-1:0]          data_out_reg;
    logic                       ready_reg;
    logic                       hit_reg;
    logic                       mem_req_reg;
    logic                       mem_we_reg;
    logic [ADDR_W-OFFSET_W-1:0] mem_addr_reg;
    logic [LINE_W-1:0]          line_out_reg;

    logic                       valid_reg [WAYS][SETS];
    logic                       dirty_reg [WAYS][SETS];
    logic [CNT_W-1:0]           cnt_reg   [WAYS][SETS];

    logic [TAG_W-1:0]           req_tag;
    logic [INDEX_W-1:0]         req_index;
    logic [OFFSET_W-1:0]        req_word;
    logic [INDEX_W-1:0]         in_index;
    logic                       rd_en;

    logic [TAG_W-1:0]           tag_rd  [WAYS];
    logic [LINE_W-1:0]          line_rd [WAYS];
    logic [WAYS-1:0]            match_vec;
    logic [WAYS-1:0]            arr_we;
    logic [LINE_W-1:0]          arr_wdata;
    logic [LINE_W-1:0]          merged_line;

    logic                       lookup_hit;
    logic [WAY_W-1:0]           hit_way;
    logic [WAY_W-1:0]           victim_way;
    logic                       victim_dirty;

    assign req_tag   = addr_reg[ADDR_W-1 -: TAG_W];
    assign req_index = addr_reg[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign req_word  = addr_reg[OFFSET_W-1:0];
    assign in_index  = address[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign rd_en     = (state_reg == IDLE) && run;

    assign Data_Out = data_out_reg;
    assign ready    = ready_reg;
    assign hit      = hit_reg;
    assign mem_req  = mem_req_reg;
    assign mem_we   = mem_we_reg;
    assign mem_addr = mem_addr_reg;
    assign Line_Out = line_out_reg;

    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [OFFSET_W-1:0] w);
        return line[w*WORD_W +: WORD_W];
    endfunction

    // Tag and data RAMs per way: read while the request is accepted, so the
    // LOOKUP cycle sees every way of the set at once.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic [TAG_W-1:0]  tag_mem  [SETS];
            logic [LINE_W-1:0] data_mem [SETS];
            logic [TAG_W-1:0]  tag_q;
            logic [LINE_W-1:0] line_q;

            always_ff @(posedge clk) begin
                if (arr_we[gi]) begin
                    tag_mem[req_index]  <= req_tag;
                    data_mem[req_index] <= arr_wdata;
                end
                if (rd_en) begin
                    tag_q  <= tag_mem[in_index];
                    line_q <= data_mem[in_index];
                end
            end

            assign tag_rd[gi]    = tag_q;
            assign line_rd[gi]   = line_q;
            assign match_vec[gi] = valid_reg[gi][req_index] && (tag_q == req_tag);
        end
    endgenerate

    always_comb begin
        merged_line = line_reg;
        merged_line[req_word*WORD_W +: WORD_W] = din_reg;
    end

    always_comb begin
        arr_we    = '0;
        arr_wdata = merged_line;
        if (!reset && state_reg == REFILL && mem_req_reg && mem_ack) begin
            arr_we[way_reg] = 1'b1;
            arr_wdata       = Line_In;
        end else if (!reset && state_reg == RESPOND && rw_reg) begin
            arr_we[way_reg] = 1'b1;
        end
    end

    // Victim: lowest invalid way, else minimum counter with lowest index on ties.
    always_comb begin
        logic             found_inv;
        logic [WAY_W-1:0] inv_way;
        logic [WAY_W-1:0] min_way;
        logic [CNT_W-1:0] min_cnt;
        lookup_hit = |match_vec;
        hit_way    = '0;
        found_inv  = 1'b0;
        inv_way    = '0;
        min_way    = '0;
        min_cnt    = cnt_reg[0][req_index];
        for (int w = 0; w < WAYS; w++) begin
            if (match_vec[w]) hit_way = w[WAY_W-1:0];
            if (!found_inv && !valid_reg[w][req_index]) begin
                found_inv = 1'b1;
                inv_way   = w[WAY_W-1:0];
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (cnt_reg[w][req_index] < min_cnt) begin
                min_cnt = cnt_reg[w][req_index];
                min_way = w[WAY_W-1:0];
            end
        end
        victim_way   = found_inv ? inv_way : min_way;
        victim_dirty = valid_reg[victim_way][req_index] && dirty_reg[victim_way][req_index];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            data_out_reg <= '0;
            ready_reg    <= 1'b0;
            hit_reg      <= 1'b0;
            mem_req_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            line_out_reg <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_reg[w][s] <= 1'b0;
                    dirty_reg[w][s] <= 1'b0;
                    cnt_reg[w][s]   <= '0;
                end
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) begin
                        addr_reg  <= address;
                        rw_reg    <= RW;
                        din_reg   <= Data_In;
                        state_reg <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_reg <= lookup_hit;
                    if (lookup_hit) begin
                        way_reg   <= hit_way;
                        line_reg  <= line_rd[hit_way];
                        ready_reg <= 1'b1;
                        if (!rw_reg) data_out_reg <= word_sel(line_rd[hit_way], req_word);
                        state_reg <= RESPOND;
                    end else begin
                        way_reg     <= victim_way;
                        mem_req_reg <= 1'b1;
                        if (victim_dirty) begin
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= {tag_rd[victim_way], req_index};
                            line_out_reg <= line_rd[victim_way];
                            state_reg    <= WRITEBACK;
                        end else begin
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= {req_tag, req_index};
                            state_reg    <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= REFILL;
                    end
                end
                REFILL: begin
                    // After a write-back the request is re-raised as a refill.
                    if (!mem_req_reg) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= {req_tag, req_index};
                    end else if (mem_ack) begin
                        mem_req_reg                  <= 1'b0;
                        line_reg                     <= Line_In;
                        valid_reg[way_reg][req_index] <= 1'b1;
                        dirty_reg[way_reg][req_index] <= 1'b0;
                        cnt_reg[way_reg][req_index]   <= CNT_ONE;
                        ready_reg                    <= 1'b1;
                        if (!rw_reg) data_out_reg <= word_sel(Line_In, req_word);
                        state_reg                    <= RESPOND;
                    end
                end
                RESPOND: begin
                    ready_reg <= 1'b0;
                    if (rw_reg) dirty_reg[way_reg][req_index] <= 1'b1;
                    if (hit_reg) begin
`ifdef LFU_AGING_EN
                        if (cnt_reg[way_reg][req_index] == CNT_MAX) begin
                            for (int w = 0; w < WAYS; w++) begin
                                if (w[WAY_W-1:0] == way_reg)
                                    cnt_reg[w][req_index] <= (cnt_reg[w][req_index] >> 1) + 1'b1;
                                else
                                    cnt_reg[w][req_index] <= cnt_reg[w][req_index] >> 1;
                            end
                        end else begin
                            cnt_reg[way_reg][req_index] <= cnt_reg[way_reg][req_index] + 1'b1;
                        end
`else
                        if (cnt_reg[way_reg][req_index] != CNT_MAX)
                            cnt_reg[way_reg][req_index] <= cnt_reg[way_reg][req_index] + 1'b1;
`endif
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
